// File: rtl/instr_fetch.sv
// instr_fetch: instruction fetch stage feeding the decoder.
//
// Keeps the fetch PC, issues word-aligned reads to instruction memory and buffers the
// in-order responses in a DEPTH-entry FIFO. Each word leaves with its PC over a
// valid/ready handshake. A redirect flushes the FIFO, marks every outstanding response
// for discard and restarts fetch at the new PC.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   imem_req_valid/ready/addr read request to instruction memory (addr = fetch PC)
//   imem_rsp_valid/data       in-order read response, no back-pressure
//   redirect_valid/pc         single-cycle restart from execute
//   inst_valid/ready          handshake towards decode
//   inst_data, inst_pc        FIFO head: instruction word and its PC
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW:0] DepthW = DEPTH[CW:0];

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   rsp_pc_q, rsp_pc_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [31:0]   pc_mem_q   [DEPTH];
  logic [31:0]   data_mem_q [DEPTH];

  logic [CW:0]   credit_used;
  logic          req_fire;
  logic          rsp_ok;
  logic          push;
  logic          pop;
  logic [31:0]   redirect_base;
  logic          unused_redirect_lsb;

  assign redirect_base       = {redirect_pc[31:2], 2'b00};
  assign unused_redirect_lsb = ^redirect_pc[1:0];

  // Buffered entries count against the credit as well as in-flight requests, so every
  // response always has a free FIFO slot and no back-pressure to memory is needed.
  assign credit_used    = {1'b0, inflight_q} + {1'b0, count_q};
  assign imem_req_valid = !rst && !redirect_valid && (credit_used < DepthW);
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response with nothing outstanding is a protocol violation and is ignored.
  assign rsp_ok = imem_rsp_valid && (inflight_q != '0);
  assign push   = rsp_ok && !redirect_valid && (drop_q == '0);
  assign pop    = (count_q != '0) && inst_ready && !redirect_valid;

  assign inst_valid = (count_q != '0);
  assign inst_data  = data_mem_q[rd_ptr_q];
  assign inst_pc    = pc_mem_q[rd_ptr_q];

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    drop_d     = drop_q;
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    inflight_d = inflight_q + {{(CW-1){1'b0}}, req_fire} - {{(CW-1){1'b0}}, rsp_ok};

    if (redirect_valid) begin
      fetch_pc_d = redirect_base;
      rsp_pc_d   = redirect_base;
      // Everything still outstanding after this cycle is stale, including responses
      // that were already marked for drop.
      drop_d     = inflight_q - {{(CW-1){1'b0}}, rsp_ok};
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (rsp_ok && (drop_q != '0)) begin
        drop_d = drop_q - 1'b1;
      end
      if (push) begin
        rsp_pc_d = rsp_pc_q + 32'd4;
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      inflight_q <= '0;
      drop_q     <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        pc_mem_q[i]   <= '0;
        data_mem_q[i] <= '0;
      end
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      if (push) begin
        pc_mem_q[wr_ptr_q]   <= rsp_pc_q;
        data_mem_q[wr_ptr_q] <= imem_rsp_data;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Testbench for instr_fetch: directed phases driving a 1-cycle-latency memory, with a
// transaction-level model (tagged outstanding-request queue plus buffer queue) compared
// against the DUT on every falling edge, and literal expectations on the observed
// instruction and request streams.
module tb_instr_fetch;

  localparam int unsigned DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data  = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc    = '0;
  logic        inst_valid;
  logic        inst_ready     = 1'b1;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;

  instr_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  // Model state
  typedef struct {
    logic [31:0] addr;
    bit          stale;
  } out_t;
  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } ent_t;

  logic [31:0] m_fetch_pc = RESET_PC;
  out_t        m_out[$];
  ent_t        m_buf[$];

  // Memory and observation logs
  logic [31:0] mem_pend[$];
  bit          hold = 1'b0;
  bit          spur = 1'b0;
  logic [31:0] log_pc[$];
  logic [31:0] log_data[$];
  logic [31:0] acc_log[$];

  function automatic logic [31:0] lp(input int i);
    if (i < log_pc.size()) return log_pc[i];
    return 'x;
  endfunction

  function automatic logic [31:0] ld(input int i);
    if (i < log_data.size()) return log_data[i];
    return 'x;
  endfunction

  function automatic logic [31:0] la(input int i);
    if (i < acc_log.size()) return acc_log[i];
    return 'x;
  endfunction

  task automatic mem_drive();
    if (spur) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'hDEAD_BEEF;
    end else if (!hold && mem_pend.size() != 0) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = word_of(mem_pend[0]);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    mem_drive();
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Compare, log, and advance the model/memory once per cycle.
  always @(negedge clk) begin
    bit   e_req;
    bit   fire;
    out_t o;
    ent_t e;
    if (rst) begin
      m_out.delete();
      m_buf.delete();
      mem_pend.delete();
      m_fetch_pc = RESET_PC;
      check("rst_inst_valid", 32'(inst_valid), 32'd0);
      check("rst_req_valid", 32'(imem_req_valid), 32'd0);
      check("rst_inst_data", inst_data, 32'd0);
    end else begin
      e_req = !redirect_valid && (m_out.size() + m_buf.size() < int'(DEPTH));
      check("req_valid", 32'(imem_req_valid), 32'(e_req));
      check("req_addr", imem_req_addr, m_fetch_pc);
      check("inst_valid", 32'(inst_valid), 32'(m_buf.size() != 0));
      if (m_buf.size() != 0) begin
        check("inst_pc", inst_pc, m_buf[0].pc);
        check("inst_data", inst_data, m_buf[0].data);
      end
      if (inst_valid && inst_ready && !redirect_valid) begin
        log_pc.push_back(inst_pc);
        log_data.push_back(inst_data);
      end
      if (imem_rsp_valid && !spur && mem_pend.size() != 0) void'(mem_pend.pop_front());
      if (imem_req_valid && imem_req_ready) begin
        acc_log.push_back(imem_req_addr);
        mem_pend.push_back(imem_req_addr);
      end
      fire = e_req && imem_req_ready;
      if (redirect_valid) begin
        foreach (m_out[i]) m_out[i].stale = 1'b1;
        m_buf.delete();
        m_fetch_pc = {redirect_pc[31:2], 2'b00};
      end else if (m_buf.size() != 0 && inst_ready) begin
        void'(m_buf.pop_front());
      end
      if (imem_rsp_valid && m_out.size() != 0) begin
        o = m_out.pop_front();
        if (!o.stale) begin
          e.pc   = o.addr;
          e.data = imem_rsp_data;
          m_buf.push_back(e);
        end
      end
      if (fire) begin
        o.addr  = m_fetch_pc;
        o.stale = 1'b0;
        m_out.push_back(o);
        m_fetch_pc = m_fetch_pc + 32'd4;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int  mark;
    int  amark;
    bit  found;

    // Reset state, then release and stream.
    repeat (3) @(posedge clk);
    #1;
    check("reset_req_valid", 32'(imem_req_valid), 32'd0);
    check("reset_inst_valid", 32'(inst_valid), 32'd0);
    check("reset_req_addr", imem_req_addr, 32'h0000_0000);
    check("reset_inst_pc", inst_pc, 32'h0000_0000);
    rst = 1'b0;
    mem_drive();
    #1;
    check("first_req_valid", 32'(imem_req_valid), 32'd1);
    cycles(14);
    check("stream_pc0", lp(0), 32'h0000_0000);
    check("stream_pc1", lp(1), 32'h0000_0004);
    check("stream_pc2", lp(2), 32'h0000_0008);
    check("stream_data1", ld(1), 32'h1357_9BDB);
    check("stream_acc2", la(2), 32'h0000_0008);

    // Asynchronous reset between edges, then restart with decode stalled.
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_inst_valid", 32'(inst_valid), 32'd0);
    check("async_rst_req_valid", 32'(imem_req_valid), 32'd0);
    inst_ready = 1'b0;
    mark = log_pc.size();
    cycle();
    rst = 1'b0;
    mem_drive();
    cycles(10);
    check("stall_inst_valid", 32'(inst_valid), 32'd1);
    check("stall_inst_pc", inst_pc, 32'h0000_0000);
    check("stall_inst_data", inst_data, 32'h1357_9BDF);
    check("stall_req_valid", 32'(imem_req_valid), 32'd0);
    inst_ready = 1'b1;
    cycles(8);
    check("resume_pc0", lp(mark), 32'h0000_0000);
    check("resume_pc1", lp(mark + 1), 32'h0000_0004);
    check("resume_pc2", lp(mark + 2), 32'h0000_0008);

    // Redirect with two responses held in flight.
    hold = 1'b1;
    mem_drive();
    cycles(4);
    check("held_req_valid", 32'(imem_req_valid), 32'd0);
    check("held_inst_valid", 32'(inst_valid), 32'd0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    mark  = log_pc.size();
    amark = acc_log.size();
    cycle();
    redirect_valid = 1'b0;
    hold = 1'b0;
    mem_drive();
    check("redir_next_inst_valid", 32'(inst_valid), 32'd0);
    check("redir_next_req_valid", 32'(imem_req_valid), 32'd0);
    cycles(10);
    check("redir_pc0", lp(mark), 32'h0000_0100);
    check("redir_pc1", lp(mark + 1), 32'h0000_0104);
    check("redir_acc0", la(amark), 32'h0000_0100);

    // Redirect in a cycle with both a response arriving and a pop.
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (imem_rsp_valid && inst_valid && m_buf.size() != 0) found = 1'b1;
      else cycle();
    end
    check("coincide_found", 32'(found), 32'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    mark = log_pc.size();
    cycle();
    redirect_valid = 1'b0;
    check("coincide_inst_valid", 32'(inst_valid), 32'd0);
    cycles(10);
    check("coincide_pc0", lp(mark), 32'h0000_0200);
    check("coincide_pc1", lp(mark + 1), 32'h0000_0204);

    // Address wrap at the top of the space.
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFF8;
    mark  = log_pc.size();
    amark = acc_log.size();
    cycle();
    redirect_valid = 1'b0;
    cycles(12);
    check("wrap_acc0", la(amark), 32'hFFFF_FFF8);
    check("wrap_acc1", la(amark + 1), 32'hFFFF_FFFC);
    check("wrap_acc2", la(amark + 2), 32'h0000_0000);
    check("wrap_pc0", lp(mark), 32'hFFFF_FFF8);
    check("wrap_pc1", lp(mark + 1), 32'hFFFF_FFFC);
    check("wrap_pc2", lp(mark + 2), 32'h0000_0000);
    check("wrap_data2", ld(mark + 2), 32'h1357_9BDF);

    // Spurious response with nothing outstanding must be ignored.
    imem_req_ready = 1'b0;
    cycles(6);
    spur = 1'b1;
    mem_drive();
    cycle();
    spur = 1'b0;
    mem_drive();
    check("spur_inst_valid", 32'(inst_valid), 32'd0);
    imem_req_ready = 1'b1;
    cycles(8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
